// File: rtl/uart_tx_fifo_port.sv
// uart_tx_fifo_port: bus-fed byte FIFO serialised as 8N1 on TXD with polled status word (CLK/RESET sync active-high; UART_TX_WE/WD in, UART_TX_RD status out, TXD serial out)
module uart_tx_fifo_port #(
  parameter int CLK_DIV    = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_TX_WE,
  input  logic [31:0] UART_TX_WD,
  output logic [31:0] UART_TX_RD,
  output logic        TXD
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0] count;
  logic ovf;
  logic [15:0] bcnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic bit_end, pop, push_req, push, full, empty, unused_wd;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = count == '0;
  assign bit_end = bcnt == 16'(CLK_DIV - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign push_req = UART_TX_WE && !UART_TX_WD[8];
  assign push = push_req && (!full || pop);
  assign unused_wd = ^UART_TX_WD[31:10];
  assign UART_TX_RD = {16'd0, 8'(count), 5'd0, ovf, full, !empty || state != IDLE};
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= UART_TX_WD[7:0];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (UART_TX_WE && UART_TX_WD[8] && UART_TX_WD[9]) ovf <= 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      TXD   <= 1'b1;
      bcnt  <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift <= mem[rd_ptr];
          bcnt  <= '0;
          state <= START;
          TXD   <= 1'b0;
        end
        START: if (bit_end) begin
          bcnt  <= '0;
          idx   <= '0;
          state <= DATA;
          TXD   <= shift[0];
        end else bcnt <= bcnt + 16'd1;
        DATA: if (bit_end) begin
          bcnt <= '0;
          if (idx == 3'd7) begin
            state <= STOP;
            TXD   <= 1'b1;
          end else begin
            shift <= shift >> 1;
            idx   <= idx + 3'd1;
            TXD   <= shift[1];
          end
        end else bcnt <= bcnt + 16'd1;
        default: if (bit_end) begin
          bcnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            TXD   <= 1'b0;
          end else state <= IDLE;
        end else bcnt <= bcnt + 16'd1;
      endcase
    end
  end
endmodule
